vi_mem_arbiter: RTL and testbench
=================================

# vi_mem_arbiter

Shares the core's single external memory port between the instruction-fetch miss path and the data-access path. Reads are 128-bit line fills and writes are 32-bit word or byte stores. The block sits between the fetch/LSU miss logic inside `vi_core` and the `mem_*` top-level ports. It serialises one transaction at a time, round-robins ties, matches returning lines by address, and bounds each read with a timeout.

## Interface
Parameters:
- `ADDR_W`, 20, byte address width of the memory port.
- `LINE_W`, 128, read line width.
- `TIMEOUT`, 64, maximum cycles spent in WAIT before a read is abandoned (≥2).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rsn_i`  in  1  reset, asynchronous, active-low.
- `ic_req_i`  in  1  instruction line-read request; held high until `ic_done_o`.
- `ic_addr_i`  in  ADDR_W  instruction fetch address.
- `ic_done_o`  out  1  one-cycle completion pulse.
- `ic_data_o`  out  LINE_W  returned line; valid while `ic_done_o` is high.
- `dc_req_i`  in  1  data request; held high with all `dc_*` inputs stable until `dc_done_o`.
- `dc_we_i`  in  1  1 = write, 0 = line read.
- `dc_byte_i`  in  1  write size: 1 = byte (`wdata[7:0]`), 0 = word.
- `dc_addr_i`  in  ADDR_W  data address.
- `dc_wdata_i`  in  32  write data.
- `dc_done_o`  out  1  one-cycle completion pulse, for both reads and writes.
- `dc_data_o`  out  LINE_W  returned line, for reads.
- `err_o`  out  1  one-cycle pulse coincident with a done pulse when that read timed out.
- `mem_read_o`  out  1  memory read strobe.
- `mem_read_addr_o`  out  ADDR_W  read address.
- `mem_data_ready_i`  in  1  memory response valid.
- `mem_data_i`  in  LINE_W  response line.
- `mem_addr_i`  in  ADDR_W  address tagged on the response.
- `mem_write_enable_o`  out  1  memory write strobe.
- `mem_write_byte_o`  out  1  byte-write flag.
- `mem_write_addr_o`  out  ADDR_W  write address.
- `mem_write_data_o`  out  32  write data.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP. Exactly one transaction is in flight at any time.
- IDLE arbitration:
  - Only `ic_req_i` high: grant IC.
  - Only `dc_req_i` high: grant DC.
  - Both high: grant the requester not granted last.
  - The `last_dc` flag is updated on every grant and resets to 0, so DC wins the first tie after reset.
- On grant, latch the owner, address, we, byte and wdata. IC grants are always reads. Next state is WR_ISSUE if DC with `dc_we_i`=1, otherwise RD_ISSUE.
- RD_ISSUE:
  - `mem_read_o`=1 and `mem_read_addr_o`=latched address, for exactly this one cycle.
  - Go to RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - Match condition: `mem_data_ready_i`=1 and `mem_addr_i[ADDR_W-1:4]` == latched `addr[ADDR_W-1:4]`.
  - On match, capture `mem_data_i` into the line register and go to RESP.
  - A ready response with a mismatching address is ignored.
  - The counter increments every cycle without a match. When it reaches TIMEOUT-1 with no match, load zero into the line register, set the error flag, and go to RESP.
- WR_ISSUE:
  - `mem_write_enable_o`=1 for this cycle only, with `mem_write_addr_o`, `mem_write_byte_o` and `mem_write_data_o` taken from the latch.
  - Writes are fire-and-forget. Go to RESP.
- RESP:
  - The owner's done pulse is high for this cycle. `err_o` is high if the error flag is set.
  - Go to IDLE and clear the error flag.
- All memory strobes and done pulses decode directly from registered state, so there are no combinational paths from inputs to outputs.
- `ic_data_o` and `dc_data_o` both drive the line register. They are meaningful only while the matching done pulse is high, and otherwise hold their last value.

## Timing
- Reset, asynchronous and immediate:
  - State goes to IDLE.
  - All strobes, done pulses and `err_o` go to 0.
  - All address, data and line outputs go to 0.
  - `last_dc`=0 and the counter is 0.
- Reset mid-transaction abandons it with no done pulse. A late `mem_data_ready_i` that arrives after reset is ignored in IDLE.
- Read latency, with the request sampled high at edge E0 (cycle 0 = IDLE):
  - `mem_read_o` is high in cycle 1.
  - A one-cycle memory returns ready in cycle 2.
  - The done pulse is high in cycle 3.
  - Minimum read latency is 3 cycles and maximum is TIMEOUT+2.
- Write latency: `mem_write_enable_o` is high in cycle 1 and the done pulse in cycle 2.
- After a done pulse the state is IDLE in the next cycle, which samples requests again. A requester that wants no further service must drop its req in that cycle.
- Changing a request's inputs before its done pulse is a protocol violation. Those inputs are sampled only at the grant edge.

## Test plan
- IC read of 0x08000 with the memory line at that address = {0x00110233, 0x002081B3, 0x00200113, 0x00100093} -> `mem_read_o` high for one cycle with addr 0x08000, `ic_done_o` in cycle 3 with that line, `err_o`=0.
- `ic_req_i` and `dc_req_i` (read) raised together after reset, both re-requesting after each done -> grant order DC, IC, DC, IC; never two strobes overlapping.
- DC byte write, addr 0x00406, wdata 0xAB -> `mem_write_enable_o`=1 and `mem_write_byte_o`=1 for one cycle with addr 0x00406 and data 0xAB, `dc_done_o` the next cycle, `mem_read_o` never asserted.
- DC read of 0x02000 with a stale response tagged 0x08000 in the first WAIT cycle and the correct response 2 cycles later -> stale response ignored, `dc_done_o` one cycle after the correct response, `dc_data_o` = correct line.
- TIMEOUT=8, memory silent -> `dc_done_o` and `err_o` pulse together in cycle 10, `dc_data_o`=0, the next pending request is granted afterwards.
- `rsn_i` dropped during RD_WAIT, then ready pulsed after release -> all outputs 0 immediately, no done pulse, the late response is ignored.

Source files
------------

// File: rtl/vi_mem_arbiter.sv
// Shares one external memory port between the instruction-fetch and data paths.
// One transaction at a time, round-robin on ties, address-matched line fills, read timeout.
module vi_mem_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_done_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic              dc_byte_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [31:0]       dc_wdata_i,
  output logic              dc_done_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              err_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_read_addr_o,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              mem_write_enable_o,
  output logic              mem_write_byte_o,
  output logic [ADDR_W-1:0] mem_write_addr_o,
  output logic [31:0]       mem_write_data_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic              owner_dc_q, owner_dc_d;
  logic              last_dc_q, last_dc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              byte_q, byte_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              err_q, err_d;

  logic              grant_ic;
  logic              grant_dc;
  logic [ADDR_W-1:0] tag_diff;
  logic              match;

  // Responses are matched on the line address only; the low nibble is the byte offset.
  assign tag_diff = mem_addr_i ^ addr_q;
  assign match    = mem_data_ready_i && ((tag_diff >> 4) == '0);

  assign grant_dc = dc_req_i && (!ic_req_i || !last_dc_q);
  assign grant_ic = ic_req_i && (!dc_req_i || last_dc_q);

  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    last_dc_d  = last_dc_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_dc) begin
          owner_dc_d = 1'b1;
          last_dc_d  = 1'b1;
          addr_d     = dc_addr_i;
          byte_d     = dc_byte_i;
          wdata_d    = dc_wdata_i;
          state_d    = dc_we_i ? S_WR_ISSUE : S_RD_ISSUE;
        end else if (grant_ic) begin
          owner_dc_d = 1'b0;
          last_dc_d  = 1'b0;
          addr_d     = ic_addr_i;
          byte_d     = 1'b0;
          state_d    = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // A match on the final wait cycle still wins over the timeout.
        if (match) begin
          line_d  = mem_data_i;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          line_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_ISSUE: state_d = S_RESP;
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= S_IDLE;
      owner_dc_q <= 1'b0;
      last_dc_q  <= 1'b0;
      addr_q     <= '0;
      byte_q     <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      last_dc_q  <= last_dc_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      err_q      <= err_d;
    end
  end

  // Every strobe and pulse decodes from registered state only.
  assign mem_read_o         = (state_q == S_RD_ISSUE);
  assign mem_read_addr_o    = addr_q;
  assign mem_write_enable_o = (state_q == S_WR_ISSUE);
  assign mem_write_byte_o   = (state_q == S_WR_ISSUE) && byte_q;
  assign mem_write_addr_o   = addr_q;
  assign mem_write_data_o   = wdata_q;
  assign ic_done_o          = (state_q == S_RESP) && !owner_dc_q;
  assign dc_done_o          = (state_q == S_RESP) && owner_dc_q;
  assign err_o              = (state_q == S_RESP) && err_q;
  assign ic_data_o          = line_q;
  assign dc_data_o          = line_q;

endmodule

// File: tb/tb_vi_mem_arbiter.sv
// Directed bench for vi_mem_arbiter: transaction vector table plus reset and tie sequences.
module tb_vi_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         ic_req_i;
  logic [19:0]  ic_addr_i;
  logic         ic_done_o;
  logic [127:0] ic_data_o;
  logic         dc_req_i;
  logic         dc_we_i;
  logic         dc_byte_i;
  logic [19:0]  dc_addr_i;
  logic [31:0]  dc_wdata_i;
  logic         dc_done_o;
  logic [127:0] dc_data_o;
  logic         err_o;
  logic         mem_read_o;
  logic [19:0]  mem_read_addr_o;
  logic         mem_data_ready_i;
  logic [127:0] mem_data_i;
  logic [19:0]  mem_addr_i;
  logic         mem_write_enable_o;
  logic         mem_write_byte_o;
  logic [19:0]  mem_write_addr_o;
  logic [31:0]  mem_write_data_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  vi_mem_arbiter #(.ADDR_W(20), .LINE_W(128), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_done_o(ic_done_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_byte_i(dc_byte_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_done_o(dc_done_o), .dc_data_o(dc_data_o), .err_o(err_o),
    .mem_read_o(mem_read_o), .mem_read_addr_o(mem_read_addr_o),
    .mem_data_ready_i(mem_data_ready_i), .mem_data_i(mem_data_i), .mem_addr_i(mem_addr_i),
    .mem_write_enable_o(mem_write_enable_o), .mem_write_byte_o(mem_write_byte_o),
    .mem_write_addr_o(mem_write_addr_o), .mem_write_data_o(mem_write_data_o)
  );

  typedef struct {
    logic         ic;
    logic         we;
    logic         byt;
    logic [19:0]  addr;
    logic [31:0]  wdata;
    int           resp_cyc;
    logic [19:0]  resp_tag;
    int           stale_cyc;
    logic [127:0] line;
    int           exp_done;
    logic         exp_err;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_idle();
    mem_data_ready_i = 1'b0;
    mem_addr_i       = '0;
    mem_data_i       = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_read_o"}, 128'(mem_read_o), 128'd0);
    chk({tag, " mem_write_enable_o"}, 128'(mem_write_enable_o), 128'd0);
    chk({tag, " dones"}, 128'({ic_done_o, dc_done_o, err_o}), 128'd0);
    chk({tag, " addrs"}, 128'({mem_read_addr_o, mem_write_addr_o}), 128'd0);
    chk({tag, " wdata/byte"}, 128'({mem_write_data_o, mem_write_byte_o}), 128'd0);
    chk({tag, " ic_data_o"}, ic_data_o, 128'd0);
    chk({tag, " dc_data_o"}, dc_data_o, 128'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int done_c = -1;
    int rd_n = 0, wr_n = 0, strobe_c = -1;
    logic [19:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic st_byte = 1'b0;
    logic got_err = 1'b0, other_done = 1'b0;
    logic [127:0] got_data = '0;
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk_i);
    ic_req_i   = v.ic;
    ic_addr_i  = v.addr;
    dc_req_i   = !v.ic;
    dc_we_i    = v.we;
    dc_byte_i  = v.byt;
    dc_addr_i  = v.addr;
    dc_wdata_i = v.wdata;
    mem_idle();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk_i); #1;
      if (mem_read_o) begin rd_n++; strobe_c = c; st_addr = mem_read_addr_o; end
      if (mem_write_enable_o) begin
        wr_n++; strobe_c = c; st_addr = mem_write_addr_o;
        st_data = mem_write_data_o; st_byte = mem_write_byte_o;
      end
      if (v.ic ? dc_done_o : ic_done_o) other_done = 1'b1;
      mem_idle();
      if (c == v.resp_cyc) begin
        mem_data_ready_i = 1'b1; mem_addr_i = v.resp_tag; mem_data_i = v.line;
      end else if (c == v.stale_cyc) begin
        mem_data_ready_i = 1'b1; mem_addr_i = 20'h08000; mem_data_i = 128'hBAD0_BAD0;
      end
      if (v.ic ? ic_done_o : dc_done_o) begin
        done_c   = c;
        got_err  = err_o;
        got_data = v.ic ? ic_data_o : dc_data_o;
        ic_req_i = 1'b0;
        dc_req_i = 1'b0;
        mem_idle();
        break;
      end
    end
    ic_req_i = 1'b0;
    dc_req_i = 1'b0;
    chk({p, " done cycle"}, 128'(done_c), 128'(v.exp_done));
    chk({p, " err"}, 128'(got_err), 128'(v.exp_err));
    chk({p, " other done"}, 128'(other_done), 128'd0);
    chk({p, " strobe cycle"}, 128'(strobe_c), 128'd1);
    chk({p, " strobe addr"}, 128'(st_addr), 128'(v.addr));
    if (v.we) begin
      chk({p, " write count"}, 128'({rd_n, wr_n}), 128'({32'd0, 32'd1}));
      chk({p, " write data"}, 128'(st_data), 128'(v.wdata));
      chk({p, " write byte"}, 128'(st_byte), 128'(v.byt));
    end else begin
      chk({p, " read count"}, 128'({rd_n, wr_n}), 128'({32'd1, 32'd0}));
      chk({p, " line"}, got_data, v.exp_data);
    end
    @(negedge clk_i);
  endtask

  logic [127:0] line0;

  initial begin
    int order[4];
    int n_done;
    int overlap;
    logic pend;
    logic [19:0] pend_addr;
    logic late_seen;

    line0 = {32'h00110233, 32'h002081B3, 32'h00200113, 32'h00100093};
    //         ic  we    byt   addr      wdata         rcyc tag       stale line          done err   exp_data
    vecs[0] = '{1'b1, 1'b0, 1'b0, 20'h08000, 32'h0, 2, 20'h08000, 0, line0, 3, 1'b0, line0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 20'h00406, 32'hAB, 0, 20'h0, 0, 128'h0, 2, 1'b0, 128'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 20'h02000, 32'h0, 4, 20'h02000, 2,
                128'h1111_2222_3333_4444_5555_6666_7777_8888, 5, 1'b0,
                128'h1111_2222_3333_4444_5555_6666_7777_8888};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 20'h01230, 32'h0, 0, 20'h0, 0, 128'h0, 10, 1'b1, 128'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 20'h00100, 32'hDEADBEEF, 0, 20'h0, 0, 128'h0, 2, 1'b0, 128'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 20'h0FFF0, 32'h0, 9, 20'h0FFFC, 0,
                128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_F0F0, 10, 1'b0,
                128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_F0F0};

    ic_req_i = 1'b0; ic_addr_i = '0;
    dc_req_i = 1'b0; dc_we_i = 1'b0; dc_byte_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0;
    mem_idle();
    rsn_i = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rsn_i = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset dropped while waiting on a line fill, then a late response after release.
    @(negedge clk_i);
    ic_req_i = 1'b1; ic_addr_i = 20'h03000;
    repeat (3) @(posedge clk_i);
    #3;
    rsn_i    = 1'b0;
    ic_req_i = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk_i);
    rsn_i = 1'b1;
    @(posedge clk_i); #1;
    mem_data_ready_i = 1'b1; mem_addr_i = 20'h03000; mem_data_i = 128'hDEAD;
    late_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      mem_idle();
      if (ic_done_o || dc_done_o || err_o || mem_read_o || mem_write_enable_o) late_seen = 1'b1;
    end
    chk("late response activity", 128'(late_seen), 128'd0);
    chk("late response data", ic_data_o, 128'd0);

    // Tie arbitration from reset: DC first, then strict alternation.
    @(negedge clk_i);
    ic_req_i = 1'b1; ic_addr_i = 20'h08000;
    dc_req_i = 1'b1; dc_we_i = 1'b0; dc_byte_i = 1'b0; dc_addr_i = 20'h02000;
    n_done = 0; overlap = 0; pend = 1'b0; pend_addr = '0;
    for (int k = 0; k < 4; k++) order[k] = 2;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      @(posedge clk_i); #1;
      if ((ic_done_o && dc_done_o) || (mem_read_o && mem_write_enable_o)) overlap++;
      mem_idle();
      if (pend) begin
        mem_data_ready_i = 1'b1; mem_addr_i = pend_addr; mem_data_i = {4{12'h0, pend_addr}};
        pend = 1'b0;
      end
      if (mem_read_o) begin pend = 1'b1; pend_addr = mem_read_addr_o; end
      if (dc_done_o) begin
        chk($sformatf("tie dc line %0d", n_done), dc_data_o, {4{12'h0, 20'h02000}});
        order[n_done] = 1; n_done++;
      end else if (ic_done_o) begin
        chk($sformatf("tie ic line %0d", n_done), ic_data_o, {4{12'h0, 20'h08000}});
        order[n_done] = 0; n_done++;
      end
      if (n_done == 4) begin ic_req_i = 1'b0; dc_req_i = 1'b0; end
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    mem_idle();
    chk("tie done count", 128'(n_done), 128'd4);
    chk("tie overlap", 128'(overlap), 128'd0);
    chk("tie grant order", 128'({order[0], order[1], order[2], order[3]}),
        128'({32'd1, 32'd0, 32'd1, 32'd0}));
    repeat (2) @(negedge clk_i);

    run_vec(6, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
